// File: rtl/alarm_set_reg.sv
// Alarm time register (BCD HH:MM) with two-button editing and a ring FSM.
// Optional snooze behaviour is enabled by defining ALARM_SNOOZE_EN.
module alarm_set_reg #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       set_mode,
  input  logic       alarm_en,
  input  logic       btn_hour,
  input  logic       btn_min,
  input  logic [3:0] t_hr_t,
  input  logic [3:0] t_hr_u,
  input  logic [3:0] t_mn_t,
  input  logic [3:0] t_mn_u,
  output logic [3:0] a_hr_t,
  output logic [3:0] a_hr_u,
  output logic [3:0] a_mn_t,
  output logic [3:0] a_mn_u,
  output logic       ring
);

  localparam int MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CNT_W    = $clog2(MAX_SECS + 1);
  localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_SECS);
  localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_SECS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

  // Bit 1 = hour button, bit 0 = minute button.
  logic [1:0] btn_s1_q, btn_s2_q, btn_prev_q;
  logic [1:0] btn_edge;

  logic [3:0] hr_t_q, hr_u_q, mn_t_q, mn_u_q;
  logic [3:0] hr_t_d, hr_u_d, mn_t_d, mn_u_d;

  logic       match_q, match_prev_q;
  logic       fire;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ring_q, ring_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_prev_q <= '0;
    end else begin
      btn_s1_q   <= {btn_hour, btn_min};
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
    end
  end

  assign btn_edge = btn_s2_q & ~btn_prev_q;

  always_comb begin
    hr_t_d = hr_t_q;
    hr_u_d = hr_u_q;
    mn_t_d = mn_t_q;
    mn_u_d = mn_u_q;
    if (set_mode && btn_edge[1]) begin
      if (hr_t_q == 4'd2 && hr_u_q == 4'd3) begin
        hr_t_d = 4'd0;
        hr_u_d = 4'd0;
      end else if (hr_u_q == 4'd9) begin
        hr_t_d = hr_t_q + 4'd1;
        hr_u_d = 4'd0;
      end else begin
        hr_u_d = hr_u_q + 4'd1;
      end
    end
    // Minutes wrap on their own; no carry into the hour field.
    if (set_mode && btn_edge[0]) begin
      if (mn_u_q == 4'd9) begin
        mn_u_d = 4'd0;
        mn_t_d = (mn_t_q == 4'd5) ? 4'd0 : mn_t_q + 4'd1;
      end else begin
        mn_u_d = mn_u_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hr_t_q <= 4'd0;
      hr_u_q <= 4'd7;
      mn_t_q <= 4'd0;
      mn_u_q <= 4'd0;
    end else begin
      hr_t_q <= hr_t_d;
      hr_u_q <= hr_u_d;
      mn_t_q <= mn_t_d;
      mn_u_q <= mn_u_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q      <= 1'b0;
      match_prev_q <= 1'b0;
    end else begin
      match_q      <= (t_hr_t == hr_t_q) && (t_hr_u == hr_u_q) &&
                      (t_mn_t == mn_t_q) && (t_mn_u == mn_u_q);
      match_prev_q <= match_q;
    end
  end

  // Edge-triggered so an alarm edited onto the current time stays silent.
  assign fire = match_q && !match_prev_q && alarm_en && !set_mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      ring_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ring_q  <= ring_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = RINGING;
          cnt_d   = RING_LD;
        end
      end
      RINGING: begin
        if (!alarm_en || set_mode) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
`ifdef ALARM_SNOOZE_EN
        end else if (|btn_edge) begin
          state_d = SNOOZE;
          cnt_d   = SNOOZE_LD;
`else
        end else if (|btn_edge) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
`endif
        end else if (tick_1hz) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q <= CNT_ONE) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (!alarm_en || set_mode) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (tick_1hz) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q <= CNT_ONE) begin
            state_d = RINGING;
            cnt_d   = RING_LD;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  always_comb begin
    ring_d = (state_d == RINGING);
  end

  assign a_hr_t = hr_t_q;
  assign a_hr_u = hr_u_q;
  assign a_mn_t = mn_t_q;
  assign a_mn_u = mn_u_q;
  assign ring   = ring_q;

endmodule
